// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store port with LATENCY wait cycles in front of an on-chip RAM.
// Optional macro DMEM_FAST_ACK_EN accepts a new request in the same cycle as the response handshake.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy
);

    localparam int AW       = $clog2(DEPTH_WORDS);
    localparam bit ZERO_LAT = (LATENCY == 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        wr_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_error_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        accept;
    logic        do_access;
    logic        acc_write;
    logic [2:0]  acc_f3;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [AW-1:0] word_idx;
    logic [31:0] rd_word;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] ld_data;
    logic [31:0] wr_word;
    logic [3:0]  be;
    logic        acc_err;
    logic        unused_addr_bits;

`ifdef DMEM_FAST_ACK_EN
    assign req_ready = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
`else
    assign req_ready = (state_q == S_IDLE);
`endif

    assign accept    = req_valid && req_ready;
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

    // With zero latency the access happens on the accept edge, straight from the request inputs.
    assign acc_write = ZERO_LAT ? req_write  : wr_q;
    assign acc_f3    = ZERO_LAT ? req_funct3 : f3_q;
    assign acc_addr  = ZERO_LAT ? req_addr   : addr_q;
    assign acc_wdata = ZERO_LAT ? req_wdata  : wdata_q;
    assign do_access = ZERO_LAT ? accept : ((state_q == S_WAIT) && (cnt_q == 4'd1));

    assign unused_addr_bits = ^acc_addr[31:AW+2];

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        word_idx  = acc_addr[AW+1:2];
        rd_word   = mem_q[word_idx];
        lane_byte = 8'(rd_word >> {acc_addr[1:0], 3'b000});
        lane_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
        acc_err   = 1'b0;
        ld_data   = '0;
        be        = '0;
        wr_word   = acc_wdata;
        if (acc_write) begin
            case (acc_f3)
                3'd0: begin
                    be      = 4'b0001 << acc_addr[1:0];
                    wr_word = {4{acc_wdata[7:0]}};
                end
                3'd1: begin
                    if (acc_addr[0]) acc_err = 1'b1;
                    else             be = acc_addr[1] ? 4'b1100 : 4'b0011;
                    wr_word = {2{acc_wdata[15:0]}};
                end
                3'd2: begin
                    if (|acc_addr[1:0]) acc_err = 1'b1;
                    else                be = 4'b1111;
                end
                default: acc_err = 1'b1;
            endcase
        end else begin
            case (acc_f3)
                3'd0: ld_data = {{24{lane_byte[7]}}, lane_byte};
                3'd1: begin
                    if (acc_addr[0]) acc_err = 1'b1;
                    else             ld_data = {{16{lane_half[15]}}, lane_half};
                end
                3'd2: begin
                    if (|acc_addr[1:0]) acc_err = 1'b1;
                    else                ld_data = rd_word;
                end
                3'd4: ld_data = {24'd0, lane_byte};
                3'd5: begin
                    if (acc_addr[0]) acc_err = 1'b1;
                    else             ld_data = {16'd0, lane_half};
                end
                default: acc_err = 1'b1;
            endcase
        end
    end

    // NOTE: the RAM array has no reset; only the write strobe is gated so a reset edge never commits a store.
    always_ff @(posedge clk) begin
        if (rst && do_access) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end

    // NOTE: all state below is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            f3_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else if (accept) begin
            wr_q    <= req_write;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= 4'(LATENCY);
            if (ZERO_LAT) begin
                state_q     <= S_RESP;
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= ld_data;
                rsp_error_q <= acc_err;
            end else begin
                state_q     <= S_WAIT;
                rsp_valid_q <= 1'b0;
            end
        end else begin
            case (state_q)
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= ld_data;
                        rsp_error_q <= acc_err;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for function/timing and a LATENCY=0 instance for throughput.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        a_req_valid = 0, a_req_write = 0, a_rsp_ready = 0;
    logic [2:0]  a_req_funct3 = 0;
    logic [31:0] a_req_addr = 0, a_req_wdata = 0;
    logic        a_req_ready, a_rsp_valid, a_rsp_error, a_busy;
    logic [31:0] a_rsp_rdata;

    logic        f_req_valid = 0, f_req_write = 0, f_rsp_ready = 0;
    logic [2:0]  f_req_funct3 = 0;
    logic [31:0] f_req_addr = 0, f_req_wdata = 0;
    logic        f_req_ready, f_rsp_valid, f_rsp_error, f_busy;
    logic [31:0] f_rsp_rdata;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef DMEM_FAST_ACK_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
        .rsp_error(a_rsp_error), .busy(a_busy)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_fast (
        .clk(clk), .rst(rst),
        .req_valid(f_req_valid), .req_ready(f_req_ready), .req_write(f_req_write),
        .req_funct3(f_req_funct3), .req_addr(f_req_addr), .req_wdata(f_req_wdata),
        .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_rdata(f_rsp_rdata),
        .rsp_error(f_rsp_error), .busy(f_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Full transaction on the LATENCY=2 instance; entered and left at a negedge with the DUT idle.
    task automatic a_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input string tag);
        int lat;
        a_req_write  = wr;
        a_req_funct3 = f3;
        a_req_addr   = addr;
        a_req_wdata  = wdata;
        a_req_valid  = 1'b1;
        check({tag, " req_ready"}, a_req_ready, 1);
        @(negedge clk);
        a_req_valid = 1'b0;
        lat = 1;
        while (!a_rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, 3);
        check({tag, " rdata"}, a_rsp_rdata, exp_rdata);
        check({tag, " error"}, a_rsp_error, exp_err);
        a_rsp_ready = 1'b1;
        @(negedge clk);
        a_rsp_ready = 1'b0;
        check({tag, " valid cleared"}, a_rsp_valid, 0);
    endtask

    // Store on the LATENCY=0 instance, response expected one cycle after accept.
    task automatic f_store(input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        f_req_write  = 1'b1;
        f_req_funct3 = 3'd2;
        f_req_addr   = addr;
        f_req_wdata  = wdata;
        f_req_valid  = 1'b1;
        @(negedge clk);
        f_req_valid = 1'b0;
        check({tag, " valid"}, f_rsp_valid, 1);
        check({tag, " error"}, f_rsp_error, 0);
        f_rsp_ready = 1'b1;
        @(negedge clk);
        f_rsp_ready = 1'b0;
        check({tag, " busy"}, f_busy, 0);
    endtask

    logic [31:0] held;
    int          wcnt;
    int          got;
    logic        rdy;

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset req_ready", a_req_ready, 1);
        check("reset rsp_valid", a_rsp_valid, 0);
        check("reset rsp_rdata", a_rsp_rdata, 0);
        check("reset rsp_error", a_rsp_error, 0);
        check("reset busy", a_busy, 0);
        rst = 1'b1;
        @(negedge clk);

        // Word store/load round trip
        a_txn(1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0, "SW 0x10");
        a_txn(0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0, "LW 0x10");

        // Byte store and sign/zero extended byte loads
        a_txn(1, 3'd0, 32'h11, 32'h00000080, 32'h0, 0, "SB 0x11");
        a_txn(0, 3'd0, 32'h11, 32'h0, 32'hFFFFFF80, 0, "LB 0x11");
        a_txn(0, 3'd4, 32'h11, 32'h0, 32'h00000080, 0, "LBU 0x11");
        a_txn(0, 3'd2, 32'h10, 32'h0, 32'hDEAD80EF, 0, "LW after SB");

        // Misaligned and illegal accesses leave memory untouched
        a_txn(1, 3'd1, 32'h13, 32'hFFFFFFFF, 32'h0, 1, "SH 0x13 misaligned");
        a_txn(0, 3'd2, 32'h12, 32'h0, 32'h0, 1, "LW 0x12 misaligned");
        a_txn(0, 3'd1, 32'h11, 32'h0, 32'h0, 1, "LH 0x11 misaligned");
        a_txn(0, 3'd3, 32'h10, 32'h0, 32'h0, 1, "load funct3=3");
        a_txn(1, 3'd4, 32'h10, 32'h0, 32'h0, 1, "store funct3=4");
        a_txn(0, 3'd2, 32'h10, 32'h0, 32'hDEAD80EF, 0, "LW after errors");
        a_txn(0, 3'd1, 32'h12, 32'h0, 32'hFFFFDEAD, 0, "LH 0x12");
        a_txn(0, 3'd5, 32'h10, 32'h0, 32'h000080EF, 0, "LHU 0x10");
        a_txn(1, 3'd1, 32'h12, 32'hFFFF1234, 32'h0, 0, "SH 0x12");
        a_txn(0, 3'd2, 32'h10, 32'h0, 32'h123480EF, 0, "LW after SH");
        a_txn(0, 3'd0, 32'h13, 32'h0, 32'h00000012, 0, "LB 0x13");

        // Response held while rsp_ready stays low
        a_req_write = 0; a_req_funct3 = 3'd2; a_req_addr = 32'h10; a_req_valid = 1'b1;
        @(negedge clk);
        a_req_valid = 1'b0;
        wcnt = 1;
        while (!a_rsp_valid && wcnt < 20) begin
            @(negedge clk);
            wcnt++;
        end
        check("hold first valid", wcnt, 3);
        held = a_rsp_rdata;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold rsp_valid", a_rsp_valid, 1);
            check("hold rsp_rdata", a_rsp_rdata, 32'h123480EF);
            check("hold req_ready", a_req_ready, 0);
            check("hold busy", a_busy, 1);
        end
        check("hold rdata first", held, 32'h123480EF);
        a_rsp_ready = 1'b1;
        @(negedge clk);
        a_rsp_ready = 1'b0;

        // Reset on the access edge of a store drops it
        a_txn(1, 3'd2, 32'h20, 32'h11111111, 32'h0, 0, "SW 0x20");
        a_req_write = 1; a_req_funct3 = 3'd2; a_req_addr = 32'h20; a_req_wdata = 32'hCAFEF00D;
        a_req_valid = 1'b1;
        @(negedge clk);
        a_req_valid = 1'b0;
        check("wait busy", a_busy, 1);
        check("wait req_ready", a_req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midreset req_ready", a_req_ready, 1);
        check("midreset rsp_valid", a_rsp_valid, 0);
        check("midreset rsp_rdata", a_rsp_rdata, 0);
        check("midreset rsp_error", a_rsp_error, 0);
        check("midreset busy", a_busy, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("idle after reset rsp_valid", a_rsp_valid, 0);
        a_txn(0, 3'd2, 32'h20, 32'h0, 32'h11111111, 0, "LW 0x20 after reset");

        // Address wrap modulo 4*DEPTH_WORDS
        a_txn(1, 3'd2, 32'h1000, 32'h12345678, 32'h0, 0, "SW 0x1000");
        a_txn(0, 3'd2, 32'h0, 32'h0, 32'h12345678, 0, "LW 0x0 wrap");

        // Back-to-back loads on the LATENCY=0 instance
        f_store(32'h0, 32'h01010101, "fast SW 0x0");
        f_store(32'h4, 32'h02020202, "fast SW 0x4");
        f_req_write = 0; f_req_funct3 = 3'd2; f_req_addr = 32'h0; f_req_valid = 1'b1;
        f_rsp_ready = 1'b1;
        @(negedge clk);
        check("b2b first valid", f_rsp_valid, 1);
        check("b2b first rdata", f_rsp_rdata, 32'h01010101);
        check("b2b req_ready in RESP", f_req_ready, FAST);
        f_req_addr = 32'h4;
        got = 0;
        for (int k = 2; k <= 8; k++) begin
            rdy = f_req_ready;
            @(negedge clk);
            if (rdy && f_req_valid) f_req_valid = 1'b0;
            if (f_rsp_valid && f_rsp_rdata === 32'h02020202 && got == 0) got = k;
        end
        f_rsp_ready = 1'b0;
        check("b2b second response cycle", got, FAST ? 2 : 3);
        check("b2b final busy", f_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
